// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state encoding, default timings and rw constants for the RTC bus controller
package rtc_bus_pkg;
    typedef enum logic [2:0] {IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, DONE} state_e;
    localparam int T_SU_DEF = 2;
    localparam int T_PW_DEF = 5;
    localparam int T_H_DEF  = 2;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable down-counter whose terminal count marks the last cycle of a phase
module rtc_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // reload on phase entry, otherwise count down and park at zero
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: address/data multiplexed bus-cycle generator for the RTC chip
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int T_SU = T_SU_DEF,
    parameter int T_PW = T_PW_DEF,
    parameter int T_H  = T_H_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);
    localparam int T_MAX = (T_SU > T_PW) ? ((T_SU > T_H) ? T_SU : T_H) : ((T_PW > T_H) ? T_PW : T_H);
    localparam int W = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

    if (T_SU < 1 || T_PW < 1 || T_H < 1) begin : g_bad_timing
        $error("rtc_bus_ctrl: T_SU, T_PW and T_H must all be at least 1");
    end

    state_e     state_q, state_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rd_data_q, rd_data_d, ad_out_q, ad_out_d;
    logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, ad_sel_q, ad_sel_d, ad_oe_q, ad_oe_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic       tc, load, accept, addr_ph, data_ph, wr_cmd;
    logic [W-1:0] load_val;

    // counter length for the phase being entered; counting ends at zero so load duration-1
    function automatic logic [W-1:0] reload(input state_e s);
        return (s == A_SU || s == D_SU) ? W'(T_SU - 1) :
               (s == A_PW || s == D_PW) ? W'(T_PW - 1) :
               (s == A_H  || s == D_H)  ? W'(T_H - 1)  : '0;
    endfunction

    assign accept   = (state_q == IDLE) && start;
    assign load     = (state_d != state_q);
    assign load_val = reload(state_d);

    rtc_phase_timer #(.W(W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .tc_o       (tc)
    );

    // next state: each timed phase advances on terminal count, DONE always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? A_SU : IDLE;
            A_SU:    state_d = tc ? A_PW : A_SU;
            A_PW:    state_d = tc ? A_H  : A_PW;
            A_H:     state_d = tc ? D_SU : A_H;
            D_SU:    state_d = tc ? D_PW : D_SU;
            D_PW:    state_d = tc ? D_H  : D_PW;
            D_H:     state_d = tc ? DONE : D_H;
            default: state_d = IDLE;
        endcase
    end

    // pin levels decoded from the next state so every pin leaves a flop aligned with state_q
    always_comb begin
        rw_d      = accept ? rw : rw_q;
        addr_d    = accept ? addr : addr_q;
        wdata_d   = accept ? wdata : wdata_q;
        addr_ph   = state_d inside {A_SU, A_PW, A_H};
        data_ph   = state_d inside {D_SU, D_PW, D_H};
        wr_cmd    = (rw_d == RW_WRITE);
        cs_n_d    = !(addr_ph || data_ph);
        ad_sel_d  = !addr_ph;
        wr_n_d    = !(state_d == A_PW || (state_d == D_PW && wr_cmd));
        rd_n_d    = !(state_d == D_PW && !wr_cmd);
        ad_oe_d   = addr_ph || (data_ph && wr_cmd);
        ad_out_d  = addr_ph ? addr_d : (data_ph && wr_cmd) ? wdata_d : 8'h00;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        rd_data_d = (state_q == D_PW && tc && rw_q == RW_READ) ? ad_in : rd_data_q;
    end

    // state, latched command, read byte and pin registers; reset forces idle pins at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rw_q      <= RW_WRITE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_sel_q  <= 1'b1;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_sel_q  <= ad_sel_d;
            ad_oe_q   <= ad_oe_d;
            ad_out_q  <= ad_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign cs_n    = cs_n_q;
    assign rd_n    = rd_n_q;
    assign wr_n    = wr_n_q;
    assign ad_sel  = ad_sel_q;
    assign ad_oe   = ad_oe_q;
    assign ad_out  = ad_out_q;
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: scoreboard bench for the RTC bus-cycle generator
module tb_rtc_bus_ctrl;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
    logic [7:0] addr = '0, wdata = '0, rd_val = '0;
    logic       busy, done, cs_n, rd_n, wr_n, ad_sel, ad_oe;
    logic [7:0] rd_data, ad_out, ad_in;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        int         done_cyc;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0;
    int   a_wr = 0, d_wr = 0, rd_cnt = 0, viol = 0, gap = 100, last_gap = 0;
    logic prev_cs = 1'b1;
    logic [7:0] rd_model = '0;

    rtc_bus_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rd_data(rd_data), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_sel(ad_sel), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    // the RTC drives its byte only while the read strobe is low
    assign ad_in = rd_n ? 8'hEE : rd_val;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // pin-trace monitor and scoreboard checker, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        e = '{rw: 1'b0, addr: 8'h00, wdata: 8'h00, rd: 8'h00, done_cyc: 0, gap: 0};
        if (q.size() != 0) begin
            e = q[0];
            rd_val = q[0].rd;
        end
        if (reset) begin
            rd_model = '0;
            a_wr = 0; d_wr = 0; rd_cnt = 0; viol = 0;
            prev_cs = 1'b1;
            gap = 100;
        end else begin
            if (prev_cs && !cs_n) begin
                last_gap = gap;
                a_wr = 0; d_wr = 0; rd_cnt = 0; viol = 0;
            end
            gap = cs_n ? gap + 1 : 0;
            prev_cs = cs_n;
            if (!cs_n) begin
                if (!wr_n && !ad_sel && ad_oe && ad_out == e.addr) a_wr++;
                if (!wr_n && ad_sel && ad_oe && ad_out == e.wdata) d_wr++;
                if (!rd_n && ad_sel && !ad_oe) rd_cnt++;
                if (!rd_n && ad_oe) viol++;
                if (!busy) viol++;
                if (e.rw && ad_sel && ad_oe) viol++;
                if (!e.rw && !rd_n) viol++;
            end
            if (done) begin
                if (q.size() == 0) chk("spurious_done", int'(done), 0);
                else begin
                    e = q.pop_front();
                    if (e.rw) rd_model = e.rd;
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("addr_strobe_cycles", a_wr, 5);
                    chk("data_wr_cycles", d_wr, e.rw ? 0 : 5);
                    chk("data_rd_cycles", rd_cnt, e.rw ? 5 : 0);
                    chk("pin_violations", viol, 0);
                    chk("rd_data", int'(rd_data), int'(rd_model));
                    chk("busy_at_done", int'(busy), 1);
                    chk("cs_n_at_done", int'(cs_n), 1);
                    if (e.gap != 0) chk("cs_gap", last_gap, e.gap);
                end
            end
        end
    end

    task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] wd, input logic [7:0] rv);
        @(negedge clk);
        rw = r; addr = a; wdata = wd; start = 1'b1;
        q.push_back('{rw: r, addr: a, wdata: wd, rd: rv, done_cyc: cyc + 19, gap: 0});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_rd_n", int'(rd_n), 1);
        chk("rst_wr_n", int'(wr_n), 1);
        chk("rst_ad_sel", int'(ad_sel), 1);
        chk("rst_ad_oe", int'(ad_oe), 0);
        chk("rst_ad_out", int'(ad_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_data", int'(rd_data), 0);

        issue(1'b0, 8'h21, 8'h45, 8'h00);
        drain();
        issue(1'b1, 8'h22, 8'h00, 8'h37);
        drain();
        issue(1'b0, 8'hFF, 8'h00, 8'h00);
        drain();
        issue(1'b1, 8'h00, 8'h00, 8'hFF);
        drain();

        issue(1'b0, 8'h21, 8'h45, 8'h00);
        repeat (3) @(negedge clk);
        rw = 1'b1; addr = 8'h99; wdata = 8'h66; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(1'b0, 8'h5C, 8'hA3, 8'h00);
        repeat (12) @(negedge clk);
        chk("pre_rst_wr_n", int'(wr_n), 0);
        chk("pre_rst_ad_sel", int'(ad_sel), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_cs_n", int'(cs_n), 1);
        chk("async_wr_n", int'(wr_n), 1);
        chk("async_ad_oe", int'(ad_oe), 0);
        chk("async_ad_sel", int'(ad_sel), 1);
        chk("async_busy", int'(busy), 0);
        chk("async_rd_data", int'(rd_data), 0);
        q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (25) @(negedge clk);
        issue(1'b1, 8'h30, 8'h00, 8'h5A);
        drain();

        @(negedge clk);
        rw = 1'b1; addr = 8'h0B; start = 1'b1;
        q.push_back('{rw: 1'b1, addr: 8'h0B, wdata: 8'h00, rd: 8'h11, done_cyc: cyc + 19, gap: 0});
        q.push_back('{rw: 1'b1, addr: 8'h0B, wdata: 8'h00, rd: 8'h22, done_cyc: cyc + 39, gap: 2});
        q.push_back('{rw: 1'b1, addr: 8'h0B, wdata: 8'h00, rd: 8'h33, done_cyc: cyc + 59, gap: 2});
        repeat (45) @(negedge clk);
        start = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
